mem_arbiter_2_1: RTL and testbench

MEM_ARBITER_2_1 -- requirements
Module: mem_arbiter_2_1

---
 rtl/mem_arbiter_2_1.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter_2_1.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2_1.sv
// Two-master to one-slave memory arbiter with alternating tie-break,
// a per-transaction wait timeout, and a saturating timeout counter.
module mem_arbiter_2_1 #(
   parameter int unsigned TIMEOUT  = 256,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        s_mem_valid0,
   output logic        s_mem_ready0,
   input  logic [31:0] s_mem_addr0,
   input  logic [31:0] s_mem_wdata0,
   input  logic [3:0]  s_mem_wstrb0,
   output logic [31:0] s_mem_rdata0,

   input  logic        s_mem_valid1,
   output logic        s_mem_ready1,
   input  logic [31:0] s_mem_addr1,
   input  logic [31:0] s_mem_wdata1,
   input  logic [3:0]  s_mem_wstrb1,
   output logic [31:0] s_mem_rdata1,

   output logic        m_mem_valid,
   input  logic        m_mem_ready,
   output logic [31:0] m_mem_addr,
   output logic [31:0] m_mem_wdata,
   output logic [3:0]  m_mem_wstrb,
   input  logic [31:0] m_mem_rdata,

   output logic        timeout_err,
   output logic [7:0]  err_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        last_grant, last_grant_nxt;
   logic [15:0] wait_cnt, wait_cnt_nxt;
   logic [7:0]  err_q, err_nxt;

   logic        sel_valid;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_wstrb;
   logic        timeout;
   logic        done;
   logic [31:0] ret_data;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wait_cnt   <= '0;
         err_q      <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         wait_cnt   <= wait_cnt_nxt;
         err_q      <= err_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      wait_cnt_nxt   = wait_cnt;
      err_nxt        = err_q;

      sel_valid = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      timeout   = 1'b0;
      done      = 1'b0;
      ret_data  = '0;

      m_mem_valid  = 1'b0;
      m_mem_addr   = '0;
      m_mem_wdata  = '0;
      m_mem_wstrb  = '0;
      s_mem_ready0 = 1'b0;
      s_mem_ready1 = 1'b0;
      s_mem_rdata0 = '0;
      s_mem_rdata1 = '0;
      timeout_err  = 1'b0;

      unique case (state)
         IDLE: begin
            // On a tie, master 0 wins only when master 1 was granted last
            if (s_mem_valid0 && (!s_mem_valid1 || last_grant)) begin
               state_nxt      = GRANT0;
               last_grant_nxt = 1'b0;
               wait_cnt_nxt   = '0;
            end else if (s_mem_valid1) begin
               state_nxt      = GRANT1;
               last_grant_nxt = 1'b1;
               wait_cnt_nxt   = '0;
            end
         end
         GRANT0: begin
            sel_valid = s_mem_valid0;
            sel_addr  = s_mem_addr0;
            sel_wdata = s_mem_wdata0;
            sel_wstrb = s_mem_wstrb0;
         end
         GRANT1: begin
            sel_valid = s_mem_valid1;
            sel_addr  = s_mem_addr1;
            sel_wdata = s_mem_wdata1;
            sel_wstrb = s_mem_wstrb1;
         end
         default: state_nxt = IDLE;
      endcase

      if (state == GRANT0 || state == GRANT1) begin
         // Slave completion in the last wait cycle beats the timeout
         timeout     = sel_valid && !m_mem_ready && (wait_cnt == WAIT_LAST);
         m_mem_valid = sel_valid && !timeout;
         done        = (sel_valid && m_mem_ready) || timeout;
         ret_data    = timeout ? ERR_DATA : m_mem_rdata;
         timeout_err = timeout;

         if (m_mem_valid) begin
            m_mem_addr  = sel_addr;
            m_mem_wdata = sel_wdata;
            m_mem_wstrb = sel_wstrb;
         end

         if (state == GRANT0) begin
            s_mem_ready0 = done;
            s_mem_rdata0 = ret_data;
         end else begin
            s_mem_ready1 = done;
            s_mem_rdata1 = ret_data;
         end

         if (!sel_valid || done) begin
            state_nxt = IDLE;
         end else begin
            wait_cnt_nxt = wait_cnt + 16'd1;
         end

         if (timeout && err_q != 8'hFF) begin
            err_nxt = err_q + 8'd1;
         end
      end

      // The visible count already includes a timeout happening this cycle
      err_cnt = err_nxt;
   end

endmodule

// File: tb/tb_mem_arbiter_2_1.sv
// Directed bench for mem_arbiter_2_1: literal checks per scenario plus a
// transaction-level model compared against every output on every cycle.
module tb_mem_arbiter_2_1;

   localparam int unsigned TO       = 4;
   localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;
   localparam logic [31:0] ADDR0    = 32'h0000_0100;
   localparam logic [31:0] ADDR1    = 32'h0000_0200;
   localparam logic [31:0] WDATA0   = 32'h1111_1111;
   localparam logic [31:0] WDATA1   = 32'h2222_2222;
   localparam logic [3:0]  WSTRB0   = 4'h0;
   localparam logic [3:0]  WSTRB1   = 4'hF;

   logic        clk;
   logic        resetn;
   logic        s_mem_valid0, s_mem_ready0, s_mem_valid1, s_mem_ready1;
   logic [31:0] s_mem_addr0, s_mem_wdata0, s_mem_rdata0;
   logic [31:0] s_mem_addr1, s_mem_wdata1, s_mem_rdata1;
   logic [3:0]  s_mem_wstrb0, s_mem_wstrb1;
   logic        m_mem_valid, m_mem_ready;
   logic [31:0] m_mem_addr, m_mem_wdata, m_mem_rdata;
   logic [3:0]  m_mem_wstrb;
   logic        timeout_err;
   logic [7:0]  err_cnt;

   int total = 0;
   int bad   = 0;

   // Model state: current owner (-1 = nobody), stalled cycles so far,
   // master granted last, and timeouts seen
   int owner;
   int waited;
   int last;
   int errs;

   mem_arbiter_2_1 #(.TIMEOUT(TO), .ERR_DATA(ERR_WORD)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .s_mem_valid0 (s_mem_valid0),
      .s_mem_ready0 (s_mem_ready0),
      .s_mem_addr0  (s_mem_addr0),
      .s_mem_wdata0 (s_mem_wdata0),
      .s_mem_wstrb0 (s_mem_wstrb0),
      .s_mem_rdata0 (s_mem_rdata0),
      .s_mem_valid1 (s_mem_valid1),
      .s_mem_ready1 (s_mem_ready1),
      .s_mem_addr1  (s_mem_addr1),
      .s_mem_wdata1 (s_mem_wdata1),
      .s_mem_wstrb1 (s_mem_wstrb1),
      .s_mem_rdata1 (s_mem_rdata1),
      .m_mem_valid  (m_mem_valid),
      .m_mem_ready  (m_mem_ready),
      .m_mem_addr   (m_mem_addr),
      .m_mem_wdata  (m_mem_wdata),
      .m_mem_wstrb  (m_mem_wstrb),
      .m_mem_rdata  (m_mem_rdata),
      .timeout_err  (timeout_err),
      .err_cnt      (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Evaluates one cycle from the arbitration rules and advances the model
   task automatic model_eval();
      logic        e_mv, e_to;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_wstrb;
      logic        e_rdy[2];
      logic [31:0] e_rd[2];
      logic [31:0] rd;
      bit          v[2];
      bit          finished;
      e_mv = 1'b0; e_to = 1'b0;
      e_addr = '0; e_wdata = '0; e_wstrb = '0;
      e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
      e_rd[0] = '0; e_rd[1] = '0;
      finished = 1'b0;
      if (!resetn) begin
         owner = -1; waited = 0; last = 1; errs = 0;
      end else if (owner < 0) begin
         v[0] = s_mem_valid0;
         v[1] = s_mem_valid1;
         if (v[0] && v[1]) owner = 1 - last;
         else if (v[0])    owner = 0;
         else if (v[1])    owner = 1;
         if (owner >= 0) begin
            last   = owner;
            waited = 0;
         end
      end else begin
         v[0] = s_mem_valid0;
         v[1] = s_mem_valid1;
         rd = m_mem_rdata;
         if (!v[owner]) begin
            finished = 1'b1;
         end else if (m_mem_ready) begin
            e_mv = 1'b1;
            e_rdy[owner] = 1'b1;
            finished = 1'b1;
         end else if (waited + 1 == int'(TO)) begin
            e_to = 1'b1;
            rd = ERR_WORD;
            e_rdy[owner] = 1'b1;
            finished = 1'b1;
            if (errs < 255) errs++;
         end else begin
            e_mv = 1'b1;
            waited++;
         end
         if (e_mv) begin
            e_addr  = (owner == 0) ? ADDR0  : ADDR1;
            e_wdata = (owner == 0) ? WDATA0 : WDATA1;
            e_wstrb = (owner == 0) ? WSTRB0 : WSTRB1;
         end
         e_rd[owner] = rd;
         if (finished) owner = -1;
      end
      chk("m_mem_valid",  32'(m_mem_valid),  32'(e_mv));
      chk("m_mem_addr",   m_mem_addr,        e_addr);
      chk("m_mem_wdata",  m_mem_wdata,       e_wdata);
      chk("m_mem_wstrb",  32'(m_mem_wstrb),  32'(e_wstrb));
      chk("s_mem_ready0", 32'(s_mem_ready0), 32'(e_rdy[0]));
      chk("s_mem_ready1", 32'(s_mem_ready1), 32'(e_rdy[1]));
      chk("s_mem_rdata0", s_mem_rdata0,      e_rd[0]);
      chk("s_mem_rdata1", s_mem_rdata1,      e_rd[1]);
      chk("timeout_err",  32'(timeout_err),  32'(e_to));
      chk("err_cnt",      32'(err_cnt),      32'(errs));
   endtask

   // Model check on the falling edge, then land just after the rising edge
   task automatic tick();
      @(negedge clk);
      model_eval();
      @(posedge clk);
      #1;
   endtask

   // Applies one cycle of stimulus; returns mid-cycle for literal checks
   task automatic step(input logic v0, input logic v1, input logic rdy, input logic [31:0] rd);
      tick();
      s_mem_valid0 = v0;
      s_mem_valid1 = v1;
      m_mem_ready  = rdy;
      m_mem_rdata  = rd;
      #2;
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      #2;
   endtask

   logic exp_r0 [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic exp_r1 [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   int   pulses;

   initial begin
      resetn = 1'b0;
      s_mem_valid0 = 1'b0; s_mem_valid1 = 1'b0;
      s_mem_addr0 = ADDR0; s_mem_addr1 = ADDR1;
      s_mem_wdata0 = WDATA0; s_mem_wdata1 = WDATA1;
      s_mem_wstrb0 = WSTRB0; s_mem_wstrb1 = WSTRB1;
      m_mem_ready = 1'b0; m_mem_rdata = '0;
      owner = -1; waited = 0; last = 1; errs = 0;

      tick();
      tick();
      chk("rst_m_valid", 32'(m_mem_valid), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_ready0",  32'(s_mem_ready0), 32'd0);
      resetn = 1'b1;

      // Single master read, slave ready after two wait cycles
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("single_idle_valid", 32'(m_mem_valid), 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("single_grant_valid", 32'(m_mem_valid), 32'd1);
      chk("single_grant_addr",  m_mem_addr, 32'h0000_0100);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h1234_5678);
      chk("single_ready0", 32'(s_mem_ready0), 32'd1);
      chk("single_rdata0", s_mem_rdata0, 32'h1234_5678);
      chk("single_ready1", 32'(s_mem_ready1), 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("single_pulse_end", 32'(s_mem_ready0), 32'd0);

      // Contention after reset with a zero-wait slave
      pulse_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b1, 32'hA0 + 32'(i));
         chk("contend_ready0", 32'(s_mem_ready0), 32'(exp_r0[i]));
         chk("contend_ready1", 32'(s_mem_ready1), 32'(exp_r1[i]));
      end

      // Master 1 times out after four stalled cycles
      step(1'b0, 1'b1, 1'b0, 32'h77);
      chk("to_idle_valid", 32'(m_mem_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'h77);
         chk("to_wait_valid", 32'(m_mem_valid), 32'd1);
      end
      step(1'b0, 1'b1, 1'b0, 32'h77);
      chk("to_ready1",  32'(s_mem_ready1), 32'd1);
      chk("to_rdata1",  s_mem_rdata1, 32'hDEAD_BEEF);
      chk("to_err",     32'(timeout_err), 32'd1);
      chk("to_err_cnt", 32'(err_cnt), 32'd1);
      chk("to_m_valid", 32'(m_mem_valid), 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("to_err_after", 32'(timeout_err), 32'd0);
      chk("to_cnt_after", 32'(err_cnt), 32'd1);

      // Slave answers in the very cycle that would have timed out
      step(1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 32'h55AA_0011);
      chk("edge_ready1",  32'(s_mem_ready1), 32'd1);
      chk("edge_rdata1",  s_mem_rdata1, 32'h55AA_0011);
      chk("edge_err",     32'(timeout_err), 32'd0);
      chk("edge_err_cnt", 32'(err_cnt), 32'd1);
      chk("edge_m_valid", 32'(m_mem_valid), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // Master 1 abandons its request while master 0 waits
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("drop_grant1_addr", m_mem_addr, 32'h0000_0200);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("drop_m_valid", 32'(m_mem_valid), 32'd0);
      chk("drop_ready1",  32'(s_mem_ready1), 32'd0);
      chk("drop_err",     32'(timeout_err), 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("drop_idle", 32'(m_mem_valid), 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("drop_next_addr", m_mem_addr, 32'h0000_0100);
      step(1'b1, 1'b0, 1'b1, 32'h0BAD_F00D);
      chk("drop_next_ready0", 32'(s_mem_ready0), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // Reset in the middle of a GRANT0 wait with both masters pending
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("mid_pre_valid", 32'(m_mem_valid), 32'd1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_valid",  32'(m_mem_valid), 32'd0);
      chk("mid_rst_addr",   m_mem_addr, 32'h0);
      chk("mid_rst_ready0", 32'(s_mem_ready0), 32'd0);
      chk("mid_rst_rdata0", s_mem_rdata0, 32'h0);
      tick();
      resetn = 1'b1;
      #2;
      chk("mid_rel_idle", 32'(m_mem_valid), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("mid_first_valid", 32'(m_mem_valid), 32'd1);
      chk("mid_first_addr",  m_mem_addr, 32'h0000_0100);
      step(1'b1, 1'b1, 1'b1, 32'h0000_600D);
      chk("mid_first_ready0", 32'(s_mem_ready0), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // 300 back-to-back timeouts saturate the counter
      pulses = 0;
      for (int i = 0; i < 1500; i++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         if (timeout_err) pulses++;
      end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("sat_pulses",  32'(pulses), 32'd300);
      chk("sat_err_cnt", 32'(err_cnt), 32'd255);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
